posit8_decode_frontend: RTL and testbench

- Two-stage pipelined decode front end for 8-bit posits (es=0), with a valid/ready handshake on both sides.
- Sits directly upstream of the combinational regime shifter. Per operand it produces:
  - the absolute-value posit that the shifter consumes to extract the 5-bit fraction;
  - sign, signed regime value, and zero/NaR flags.
- Decouples the operand source from the datapath.

---
 rtl/posit8_decode_frontend.sv | 161 ++++++++++++++++
 tb/tb_posit8_decode_frontend.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit8_decode_frontend.sv
// posit8_decode_frontend: two-stage valid/ready decode front end for 8-bit
// posits (es=0). Stage 1 captures sign, zero/NaR flags and the two's-complement
// magnitude; stage 2 (output registers) adds the signed regime value.
// Optional build macro: POSIT8_DECODE_NAR_COUNT_EN adds nar_count, a
// saturating count of NaR operands accepted at the input.

module posit8_decode_frontend (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_posit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_abs,
    output logic       out_sign,
    output logic [3:0] out_regime,
    output logic       out_zero,
    output logic       out_nar
`ifdef POSIT8_DECODE_NAR_COUNT_EN
    ,
    output logic [7:0] nar_count
`endif
);

    localparam int unsigned W = 8;
    localparam int unsigned RW = 4;
    localparam logic [W-1:0] POSIT_ZERO = 8'h00;
    localparam logic [W-1:0] POSIT_NAR = 8'h80;

    // Regime from a magnitude: run of bits equal to abs[6], capped at 7.
    function automatic logic [RW-1:0] regime_of(input logic [W-1:0] a);
        logic [2:0] k;
        logic       run;
        k   = 3'd0;
        run = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            if (run && (a[i] == a[6])) begin
                k = k + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        regime_of = a[6] ? (RW'(k) - 4'd1) : (4'd0 - RW'(k));
    endfunction

    logic           s1_valid_q, s1_valid_d;
    logic           s1_sign_q, s1_sign_d;
    logic           s1_zero_q, s1_zero_d;
    logic           s1_nar_q, s1_nar_d;
    logic [W-1:0]   s1_abs_q, s1_abs_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_abs_q, out_abs_d;
    logic           out_sign_q, out_sign_d;
    logic [RW-1:0]  out_regime_q, out_regime_d;
    logic           out_zero_q, out_zero_d;
    logic           out_nar_q, out_nar_d;
    logic           s1_load_c;
    logic           s2_load_c;
    logic           special_c;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
    logic [W-1:0]   nar_count_q, nar_count_d;
`endif

    // Handshake control and next-state for both stages.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_zero_d    = s1_zero_q;
        s1_nar_d     = s1_nar_q;
        s1_abs_d     = s1_abs_q;
        out_valid_d  = out_valid_q;
        out_abs_d    = out_abs_q;
        out_sign_d   = out_sign_q;
        out_regime_d = out_regime_q;
        out_zero_d   = out_zero_q;
        out_nar_d    = out_nar_q;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
        nar_count_d  = nar_count_q;
`endif

        s2_load_c = s1_valid_q && (!out_valid_q || out_ready);
        s1_load_c = in_valid && (!s1_valid_q || s2_load_c);
        special_c = s1_zero_q || s1_nar_q;

        if (s1_load_c) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_posit[7];
            s1_zero_d  = (in_posit == POSIT_ZERO);
            s1_nar_d   = (in_posit == POSIT_NAR);
            s1_abs_d   = in_posit[7] ? W'(~in_posit + 8'd1) : in_posit;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load_c) begin
            out_valid_d  = 1'b1;
            out_abs_d    = s1_abs_q;
            out_sign_d   = s1_sign_q && !special_c;
            out_regime_d = special_c ? 4'd0 : regime_of(s1_abs_q);
            out_zero_d   = s1_zero_q;
            out_nar_d    = s1_nar_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef POSIT8_DECODE_NAR_COUNT_EN
        if (s1_load_c && (in_posit == POSIT_NAR) && (nar_count_q != 8'hFF)) begin
            nar_count_d = nar_count_q + 8'd1;
        end
`endif
    end

    // Pipeline state registers; reset discards any in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_nar_q     <= 1'b0;
            s1_abs_q     <= '0;
            out_valid_q  <= 1'b0;
            out_abs_q    <= '0;
            out_sign_q   <= 1'b0;
            out_regime_q <= '0;
            out_zero_q   <= 1'b0;
            out_nar_q    <= 1'b0;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
            nar_count_q  <= '0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_nar_q     <= s1_nar_d;
            s1_abs_q     <= s1_abs_d;
            out_valid_q  <= out_valid_d;
            out_abs_q    <= out_abs_d;
            out_sign_q   <= out_sign_d;
            out_regime_q <= out_regime_d;
            out_zero_q   <= out_zero_d;
            out_nar_q    <= out_nar_d;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
            nar_count_q  <= nar_count_d;
`endif
        end
    end

    // in_ready looks through to out_ready so a full pipe still streams.
    assign in_ready   = !s1_valid_q || s2_load_c;
    assign out_valid  = out_valid_q;
    assign out_abs    = out_abs_q;
    assign out_sign   = out_sign_q;
    assign out_regime = out_regime_q;
    assign out_zero   = out_zero_q;
    assign out_nar    = out_nar_q;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
    assign nar_count  = nar_count_q;
`endif

endmodule

// File: tb/tb_posit8_decode_frontend.sv
// Scoreboard bench for posit8_decode_frontend: the driver pushes a model
// result per accepted operand, a monitor pops and compares per output beat.
module tb_posit8_decode_frontend;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_posit;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_abs;
    logic       out_sign;
    logic [3:0] out_regime;
    logic       out_zero;
    logic       out_nar;
`ifdef POSIT8_DECODE_NAR_COUNT_EN
    logic [7:0] nar_count;
`endif

    always #5 clk = ~clk;

    posit8_decode_frontend dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_posit   (in_posit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_abs    (out_abs),
        .out_sign   (out_sign),
        .out_regime (out_regime),
        .out_zero   (out_zero),
        .out_nar    (out_nar)
`ifdef POSIT8_DECODE_NAR_COUNT_EN
        ,
        .nar_count  (nar_count)
`endif
    );

    typedef struct {
        logic [7:0] abs_v;
        logic       sign;
        logic [3:0] regime;
        logic       zero;
        logic       nar;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;
    int   nar_model = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decode straight from the posit definition using integers.
    function automatic exp_t model(input logic [7:0] p);
        exp_t e;
        int mag, r, x, msb, k, rg;
        mag = (p >= 8'd128) ? (256 - int'(p)) % 256 : int'(p);
        e.abs_v = 8'(mag);
        e.zero  = (p == 8'h00);
        e.nar   = (p == 8'h80);
        r = (mag >> 6) & 1;
        x = (r == 1) ? (~mag & 127) : (mag & 127);
        msb = -1;
        while ((1 << (msb + 1)) <= x) msb++;
        k = (x == 0) ? 7 : 6 - msb;
        rg = (r == 1) ? k - 1 : -k;
        if (e.zero || e.nar) rg = 0;
        e.regime = 4'(rg);
        e.sign = p[7] && !e.zero && !e.nar;
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // One cycle of stimulus; records the expected result if accepted.
    task automatic drive(input logic [7:0] p, input logic v, input logic ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_posit  = p;
        out_ready = ordy;
        #2;
        acc = in_valid && in_ready;
        if (acc) begin
            e = model(p);
            e.acc_cyc = cyc;
            e.chk_lat = lat_mode;
            sb.push_back(e);
            if (p == 8'h80 && nar_model < 255) nar_model++;
        end
    endtask

    // Monitor: pops on each output transfer, and checks stall stability.
    bit         held = 1'b0;
    logic [15:0] held_vec;
    initial begin
        exp_t e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            #3;
            got = {out_abs, out_sign, out_regime, out_zero, out_nar, 1'b0};
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checks++;
                if (!out_valid || got != held_vec) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b data=%h expected valid=1 data=%h",
                             out_valid, got, held_vec);
                end
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                pop_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: abs=%h with empty scoreboard", out_abs);
                end else begin
                    e = sb.pop_front();
                    if (out_abs != e.abs_v || out_sign != e.sign || out_regime != e.regime ||
                        out_zero != e.zero || out_nar != e.nar) begin
                        failures++;
                        $display("FAIL decode: got abs=%h sign=%0b reg=%h z=%0b n=%0b expected abs=%h sign=%0b reg=%h z=%0b n=%0b",
                                 out_abs, out_sign, out_regime, out_zero, out_nar,
                                 e.abs_v, e.sign, e.regime, e.zero, e.nar);
                    end
                    if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
                end
            end else if (out_valid) begin
                held = 1'b1;
                held_vec = got;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        bit acc;
        int n;
        logic [7:0] dir [8];
        dir = '{8'h40, 8'hC0, 8'h7F, 8'h01, 8'h20, 8'h60, 8'h00, 8'h80};
        rst = 1'b1; in_valid = 1'b0; in_posit = 8'h00; out_ready = 1'b1;
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_abs", int'(out_abs), 0);
        check("reset_out_regime", int'(out_regime), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Directed single beats, each drained before the next.
        lat_mode = 1'b1;
        foreach (dir[i]) begin
            drive(dir[i], 1'b1, 1'b1, acc);
            check("single_accept", int'(acc), 1);
            repeat (3) drive(8'h00, 1'b0, 1'b1, acc);
        end
        lat_mode = 1'b0;

        // 16-beat back-to-back stream.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom), 1'b1, 1'b1, acc);
            check("stream_in_ready", int'(acc), 1);
        end
        repeat (3) drive(8'h00, 1'b0, 1'b1, acc);
        check("stream_count", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) check("stream_consecutive", pop_cyc[15] - pop_cyc[0], 15);

        // Backpressure mid-stream.
        repeat (3) drive(8'($urandom), 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++) drive(8'($urandom), 1'b1, 1'b0, acc);
        check("full_in_ready", int'(in_ready), 0);
        repeat (4) drive(8'($urandom), 1'b1, 1'b1, acc);
        repeat (3) drive(8'h00, 1'b0, 1'b1, acc);
        check("backpressure_drained", sb.size(), 0);

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] p;
            p = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            drive(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), acc);
        end
        repeat (3) drive(8'h00, 1'b0, 1'b1, acc);
        check("random_drained", sb.size(), 0);
`ifdef POSIT8_DECODE_NAR_COUNT_EN
        check("nar_count_random", int'(nar_count), nar_model);
`endif

        // Reset with both stages full.
        n = 0;
        while (in_ready && n < 10) begin
            drive(8'($urandom), 1'b1, 1'b0, acc);
            n++;
        end
        check("pre_reset_full", int'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        sb.delete();
        nar_model = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) drive(8'h00, 1'b0, 1'b1, acc);
`ifdef POSIT8_DECODE_NAR_COUNT_EN
        check("nar_count_after_reset", int'(nar_count), 0);
        for (int i = 0; i < 300; i++) drive(8'h80, 1'b1, 1'b1, acc);
        repeat (3) drive(8'h00, 1'b0, 1'b1, acc);
        check("nar_count_saturate", int'(nar_count), 255);
`endif

        // Bounded final drain.
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            drive(8'h00, 1'b0, 1'b1, acc);
            n++;
        end
        check("final_scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
